cfg_serial_loader: RTL and testbench
====================================

Name: cfg_serial_loader

Overview:
- Front end of the fabric configuration path.
- Receives an externally clocked serial bitstream on three chip pins (sclk, sdata, cs_n) and synchronises it into clk.
- Strips a 16-bit length header and re-emits the payload as a 1-bit AXI stream; tlast marks the final payload bit.
- Its stream feeds the LUT/CLB config chain. It raises the fabric cfg request, then reports completion or error.

Parameters:
- LEN_WIDTH, 16, width of the frame-length header in bits (MSB first).
- FIFO_DEPTH, 8, depth of the payload bit FIFO between pin domain logic and stream output; power of two, >= 2.
- SYNC_STAGES, 2, flip-flop stages on each pin input.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- pin_sclk  input  1  external serial clock, asynchronous to clk; data sampled on its rising edge.
- pin_sdata  input  1  external serial data.
- pin_cs_n  input  1  frame select, active-low.
- cfg  output  1  held high from header accept until frame end; drives fabric cfg.
- cfg_bitstream  axi_stream_if.master  -  tdata[0] = payload bit, plus tvalid/tready/tlast.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last payload beat is accepted downstream.
- err_overrun  output  1  sticky; set when a sampled payload bit finds the FIFO full.
- err_abort  output  1  sticky; set when cs_n deasserts before all header or payload bits arrive.

Behaviour:
- Reset values: cfg=0, tvalid=0, tlast=0, tdata=0, busy=0, done=0, both error flags 0, FIFO empty, state IDLE. Reset mid-frame discards everything.
- Synchronisers: each pin passes through SYNC_STAGES flops. Synchronised signals are power-up-reset to the idle pin levels: sclk=0, cs_n=1.
- Edge detect: a sclk rising edge is synced sclk==1 while the previous synced sclk==0. A bit is sampled only on that edge and only while synced cs_n==0.
- External sclk must be <= clk/4; this is a documented constraint, not checked by the block.
- States:
  - IDLE: on synced cs_n falling, clear both error flags, clear counters -> HEADER.
  - HEADER: shift sampled bits into the length register, MSB first. After LEN_WIDTH bits:
    - length==0 -> pulse done, -> WAIT_CS.
    - else assert cfg, -> PAYLOAD.
  - PAYLOAD: each sampled bit is pushed to the FIFO, tagged with last = (bit count == length). Once the last-tagged bit is pushed -> DRAIN.
  - DRAIN: wait until the last-tagged beat handshakes (tvalid&&tready&&tlast). In that cycle pulse done; next cycle deassert cfg -> WAIT_CS.
  - WAIT_CS: wait for synced cs_n==1 -> IDLE. Extra sclk edges here are ignored.
- cs_n rises in HEADER or PAYLOAD: set err_abort, flush FIFO, drop tvalid the next cycle, deassert cfg, -> IDLE. No tlast is emitted; no done pulse.
- FIFO full when a payload bit is sampled: the bit is dropped, err_overrun set, the bit counter still advances. If the dropped bit was the last, tlast is never sent: the FSM stays in DRAIN until cs_n rises, then sets err_abort and returns to IDLE.
- Simultaneous push and pop on a full FIFO is allowed (pop frees the slot first), so no overrun in that case.
- Stream output: tvalid = FIFO non-empty (registered FIFO head, no combinational path from pins); tdata and tlast are stable while tvalid && !tready.
- Latency: sampled bit -> tvalid at most 2 clk after the synchronised edge, given an empty FIFO.
- Length counter is LEN_WIDTH bits and does not wrap: the maximum frame is 2^LEN_WIDTH-1 bits.

Decomposition:
- Package cfg_loader_pkg: state enum cfg_loader_state_t (IDLE, HEADER, PAYLOAD, DRAIN, WAIT_CS) and the default LEN_WIDTH constant.
- One sub-module, bit_fifo: synchronous FIFO holding {last,data}, with push/pop/full/empty/flush. The FSM, synchronisers and edge detect stay in cfg_serial_loader.

Test Plan:
- Header 0x0004, payload 1,0,1,1, tready=1, sclk=clk/8 -> tdata beats 1,0,1,1; tlast only on the 4th; done pulses once; cfg high from header end until the cycle after done; no errors.
- Same frame with tready held 0 until all bits are sent, FIFO_DEPTH=8 -> 4 beats buffered; on release they drain in order 1,0,1,1 on consecutive cycles; no err_overrun.
- Header 0x000C, tready=0 throughout -> 8 bits buffered; the 9th sampled bit sets err_overrun; the FSM parks in DRAIN until cs_n rises, then err_abort=1 and state returns to IDLE.
- Header 0x0008, cs_n rises after 3 payload bits -> err_abort=1, tvalid=0 within 1 cycle of synced cs_n high, no tlast, no done, busy=0.
- Header 0x0000 -> done pulses, cfg never asserts, no beats emitted.
- rst asserted mid-PAYLOAD -> all outputs at reset values next cycle; a following full frame completes normally with errors 0.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared types and defaults for the serial configuration loader.
//   cfg_loader_state_t     - loader FSM states
//   CFG_LEN_WIDTH_DEFAULT  - default width of the frame-length header
//   state_in_frame()       - true while header/payload bits are still expected
package cfg_loader_pkg;

  localparam int CFG_LEN_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    DRAIN   = 3'd3,
    WAIT_CS = 3'd4
  } cfg_loader_state_t;

  // A frame ending in either of these states is incomplete.
  function automatic logic state_in_frame(cfg_loader_state_t s);
    return (s == HEADER) || (s == PAYLOAD);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// axi_stream_if: minimal AXI4-Stream bundle.
//   tdata  - payload, DATA_W bits
//   tvalid - source has a beat
//   tready - sink accepts the beat
//   tlast  - final beat of the packet
interface axi_stream_if #(
  parameter int DATA_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/cfg_serial_loader_bit_fifo.sv
// bit_fifo: small synchronous FIFO for the loader payload path.
//   clk, rst   - clock, synchronous active-high reset (pointers/count only)
//   flush      - discard all entries
//   push/push_data - write request and entry ({last, data})
//   pop        - read request; head advances on the next edge
//   head       - current oldest entry (registered storage, no input bypass)
//   full/empty - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module bit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cfg_serial_loader.sv
// cfg_serial_loader: serial configuration front end.
//   clk, rst       - system clock, synchronous active-high reset
//   pin_sclk       - external serial clock (async), data taken on its rising edge
//   pin_sdata      - external serial data
//   pin_cs_n       - frame select, active-low
//   cfg            - high from header accept until the cycle after done
//   cfg_bitstream  - 1-bit AXI stream of payload bits, tlast on the final bit
//   busy           - FSM not idle
//   done           - one-cycle pulse on final beat accepted (or empty frame)
//   err_overrun    - sticky: a payload bit was dropped on a full FIFO
//   err_abort      - sticky: frame ended early by cs_n
// Frames are a LEN_WIDTH-bit length header (MSB first) followed by that many
// payload bits. sclk must be no faster than clk/4.
module cfg_serial_loader
  import cfg_loader_pkg::*;
#(
  parameter int LEN_WIDTH   = CFG_LEN_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pin_sclk,
  input  logic         pin_sdata,
  input  logic         pin_cs_n,
  output logic         cfg,
  axi_stream_if.master cfg_bitstream,
  output logic         busy,
  output logic         done,
  output logic         err_overrun,
  output logic         err_abort
);

  localparam int HDR_CW = $clog2(LEN_WIDTH + 1);
  localparam logic [HDR_CW-1:0] HDR_LAST = HDR_CW'(LEN_WIDTH - 1);

  cfg_loader_state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   sdata_s;
  logic                   sample;
  logic                   cs_fall;

  logic [HDR_CW-1:0]      hdr_cnt;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   len_next;
  logic [LEN_WIDTH-1:0]   bit_cnt;
  logic [LEN_WIDTH-1:0]   bit_cnt_inc;
  logic                   last_dropped;

  logic                   hdr_done;
  logic                   pay_sample;
  logic                   pay_last;
  logic                   overrun;
  logic                   abort;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [1:0]             fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   last_pop;

  // ---- pin synchronisers: control pins reset to their idle levels ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync[0] <= pin_sclk;
      cs_sync[0]   <= pin_cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Data follows the same depth as sclk so it lines up with the detected edge.
  always_ff @(posedge clk) begin
    sdata_sync[0] <= pin_sdata;
    for (int i = 1; i < SYNC_STAGES; i++) sdata_sync[i] <= sdata_sync[i-1];
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign sample  = sclk_s & ~sclk_prev & ~cs_s;
  assign cs_fall = cs_prev & ~cs_s;

  // ---- frame decode ----
  assign len_next    = {len_reg[LEN_WIDTH-2:0], sdata_s};
  assign hdr_done    = (state == HEADER) && sample && (hdr_cnt == HDR_LAST);
  assign pay_sample  = (state == PAYLOAD) && sample;
  assign bit_cnt_inc = bit_cnt + 1'b1;
  assign pay_last    = (bit_cnt_inc == len_reg);

  // A pop in the same cycle frees a slot, so only a stalled full FIFO drops.
  assign fifo_pop  = ~fifo_empty & cfg_bitstream.tready;
  assign overrun   = pay_sample & fifo_full & ~fifo_pop;
  assign fifo_push = pay_sample & ~overrun;
  assign last_pop  = fifo_pop & fifo_head[1];

  // With the last bit dropped, tlast can never appear; cs_n rising ends it.
  assign abort = cs_s & (state_in_frame(state) || ((state == DRAIN) && last_dropped));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = HEADER;
      end
      HEADER: begin
        if (abort)         state_nxt = IDLE;
        else if (hdr_done) state_nxt = (len_next == '0) ? WAIT_CS : PAYLOAD;
      end
      PAYLOAD: begin
        if (abort)                      state_nxt = IDLE;
        else if (pay_sample && pay_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop)   state_nxt = WAIT_CS;
        else if (abort) state_nxt = IDLE;
      end
      WAIT_CS: begin
        if (cs_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy = (state != IDLE);
    cfg  = (state == PAYLOAD) || (state == DRAIN);
    done = 1'b0;
    case (state)
      HEADER:  done = hdr_done && (len_next == '0);
      DRAIN:   done = last_pop;
      default: done = 1'b0;
    endcase
  end

  // ---- counters and sticky flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt      <= '0;
      bit_cnt      <= '0;
      last_dropped <= 1'b0;
      err_overrun  <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      if ((state == IDLE) && cs_fall) begin
        hdr_cnt      <= '0;
        bit_cnt      <= '0;
        last_dropped <= 1'b0;
        err_overrun  <= 1'b0;
        err_abort    <= 1'b0;
      end
      if ((state == HEADER) && sample) hdr_cnt <= hdr_cnt + 1'b1;
      // The bit counter advances even for a dropped bit so the frame length holds.
      if (pay_sample) begin
        bit_cnt <= bit_cnt_inc;
        if (overrun) begin
          err_overrun <= 1'b1;
          if (pay_last) last_dropped <= 1'b1;
        end
      end
      if (abort) err_abort <= 1'b1;
    end
  end

  // Header shift register is fully reloaded each frame, so no reset needed.
  always_ff @(posedge clk) begin
    if ((state == HEADER) && sample) len_reg <= len_next;
  end

  // ---- payload FIFO and stream output ----
  bit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_bit_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (fifo_push),
    .push_data ({pay_last, sdata_s}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is masked while empty so stale storage never shows on tdata/tlast.
  always_comb begin
    cfg_bitstream.tvalid   = ~fifo_empty;
    cfg_bitstream.tdata    = '0;
    cfg_bitstream.tdata[0] = ~fifo_empty & fifo_head[0];
    cfg_bitstream.tlast    = ~fifo_empty & fifo_head[1];
  end

endmodule

// File: tb/tb_cfg_serial_loader.sv
module tb_cfg_serial_loader;

  localparam int LEN_W = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin_sclk = 1'b0;
  logic pin_sdata = 1'b0;
  logic pin_cs_n = 1'b1;
  logic cfg, busy, done, err_overrun, err_abort;

  axi_stream_if #(.DATA_W(1)) bs ();

  cfg_serial_loader #(
    .LEN_WIDTH   (LEN_W),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pin_sclk      (pin_sclk),
    .pin_sdata     (pin_sdata),
    .pin_cs_n      (pin_cs_n),
    .cfg           (cfg),
    .cfg_bitstream (bs),
    .busy          (busy),
    .done          (done),
    .err_overrun   (err_overrun),
    .err_abort     (err_abort)
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stream monitor ----------------
  int  cyc = 0;
  bit  rx_d[$];
  bit  rx_l[$];
  int  rx_c[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  cfg_hi = 0;
  int  cfg_fall_cyc = 0;
  int  stab_err = 0;
  logic cfg_at_done = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pd = 1'b0, pl = 1'b0, pcfg = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bs.tvalid && bs.tready) begin
      rx_d.push_back(bs.tdata[0]);
      rx_l.push_back(bs.tlast);
      rx_c.push_back(cyc);
    end
    if (done) begin
      done_cnt    <= done_cnt + 1;
      done_cyc    <= cyc;
      cfg_at_done <= cfg;
    end
    if (cfg) cfg_hi <= cfg_hi + 1;
    if (pcfg && !cfg) cfg_fall_cyc <= cyc;
    if (pv && !pr && bs.tvalid && ((bs.tdata[0] !== pd) || (bs.tlast !== pl)))
      stab_err <= stab_err + 1;
    pv   <= bs.tvalid;
    pr   <= bs.tready;
    pd   <= bs.tdata[0];
    pl   <= bs.tlast;
    pcfg <= cfg;
  end

  // ---------------- tready driver: 0 low, 1 high, 2 random ----------------
  int rdy_mode = 1;
  int lowrun = 0;

  initial begin
    bs.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bs.tready = 1'b0;
        1: bs.tready = 1'b1;
        default: begin
          // never more than two idle cycles in a row, so an 8-clk sclk cannot overrun
          if (lowrun >= 2) bs.tready = 1'b1;
          else             bs.tready = 1'($urandom_range(0, 1));
          lowrun = bs.tready ? 0 : lowrun + 1;
        end
      endcase
    end
  end

  // ---------------- pin stimulus ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sclk at clk/8: four clocks low, four clocks high
  task automatic send_bit(bit b);
    pin_sdata = b;
    pin_sclk  = 1'b0;
    tick(4);
    pin_sclk  = 1'b1;
    tick(4);
    pin_sclk  = 1'b0;
  endtask

  task automatic send_word(logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic cs_low();
    pin_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    pin_sclk = 1'b0;
    tick(4);
    pin_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wait_done(int base);
    for (int i = 0; i < 300 && done_cnt == base; i++) tick(1);
  endtask

  // ---------------- reference model ----------------
  // Expected beats are simply the payload bits in order, tlast on the final one.
  bit exp_q[$];
  int b_rx, b_done, b_cfg, b_stab;

  task automatic fill_rand(int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic check_rx(string tag, int base);
    check_eq({tag, "_nbeats"}, 32'(rx_d.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_d.size()) begin
        check_eq($sformatf("%s_d%0d", tag, i), 32'(rx_d[base+i]), 32'(exp_q[i]));
        check_eq($sformatf("%s_l%0d", tag, i), 32'(rx_l[base+i]), 32'(i == exp_q.size() - 1));
      end
    end
  endtask

  task automatic run_frame(string tag, int mode);
    b_rx   = rx_d.size();
    b_done = done_cnt;
    b_stab = stab_err;
    b_cfg  = cfg_hi;
    rdy_mode = mode;
    cs_low();
    send_word(16'(exp_q.size()));
    foreach (exp_q[i]) send_bit(exp_q[i]);
    wait_done(b_done);
    tick(2);
    cs_high();
    check_rx(tag, b_rx);
    check_eq({tag, "_done"},    32'(done_cnt - b_done), 32'd1);
    check_eq({tag, "_overrun"}, 32'(err_overrun), 32'd0);
    check_eq({tag, "_abort"},   32'(err_abort), 32'd0);
    check_eq({tag, "_stable"},  32'(stab_err - b_stab), 32'd0);
    check_eq({tag, "_busy"},    32'(busy), 32'd0);
    check_eq({tag, "_cfg_end"}, 32'(cfg), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic ok;

  initial begin
    rst = 1'b1;
    tick(4);
    @(negedge clk);
    check_eq("rst_cfg",     32'(cfg), 32'd0);
    check_eq("rst_tvalid",  32'(bs.tvalid), 32'd0);
    check_eq("rst_tlast",   32'(bs.tlast), 32'd0);
    check_eq("rst_tdata",   32'(bs.tdata[0]), 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    check_eq("rst_done",    32'(done), 32'd0);
    check_eq("rst_overrun", 32'(err_overrun), 32'd0);
    check_eq("rst_abort",   32'(err_abort), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);

    // basic 4-bit frame, tready high
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame("basic", 1);
    check_eq("basic_cfg_at_done", 32'(cfg_at_done), 32'd1);
    check_eq("basic_cfg_fall",    32'(cfg_fall_cyc), 32'(done_cyc + 1));
    check_eq("basic_cfg_seen",    32'((cfg_hi - b_cfg) > 0), 32'd1);

    // same frame buffered behind tready low, then released
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    b_rx = rx_d.size();
    b_done = done_cnt;
    rdy_mode = 0;
    tick(2);
    cs_low();
    send_word(16'd4);
    send_bit(1'b1);
    check_eq("buf_lat_tvalid", 32'(bs.tvalid), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick(4);
    check_eq("buf_hold_tvalid", 32'(bs.tvalid), 32'd1);
    check_eq("buf_hold_tdata",  32'(bs.tdata[0]), 32'd1);
    check_eq("buf_hold_tlast",  32'(bs.tlast), 32'd0);
    check_eq("buf_no_beats",    32'(rx_d.size() - b_rx), 32'd0);
    rdy_mode = 1;
    wait_done(b_done);
    tick(2);
    cs_high();
    check_rx("buf", b_rx);
    ok = 1'b1;
    if (rx_d.size() < b_rx + 4) ok = 1'b0;
    else for (int i = 1; i < 4; i++) if (rx_c[b_rx+i] != rx_c[b_rx+i-1] + 1) ok = 1'b0;
    check_eq("buf_consecutive", 32'(ok), 32'd1);
    check_eq("buf_done",    32'(done_cnt - b_done), 32'd1);
    check_eq("buf_overrun", 32'(err_overrun), 32'd0);

    // 12-bit frame with tready low: 9th bit overruns, FSM parks until cs_n
    fill_rand(12);
    b_rx = rx_d.size();
    b_done = done_cnt;
    rdy_mode = 0;
    tick(2);
    cs_low();
    send_word(16'd12);
    for (int i = 0; i < DEPTH; i++) send_bit(exp_q[i]);
    check_eq("ovr_before",    32'(err_overrun), 32'd0);
    send_bit(exp_q[DEPTH]);
    check_eq("ovr_after",     32'(err_overrun), 32'd1);
    check_eq("ovr_head_data", 32'(bs.tdata[0]), 32'(exp_q[0]));
    for (int i = DEPTH + 1; i < 12; i++) send_bit(exp_q[i]);
    tick(6);
    check_eq("ovr_park_busy",  32'(busy), 32'd1);
    check_eq("ovr_park_cfg",   32'(cfg), 32'd1);
    check_eq("ovr_park_abort", 32'(err_abort), 32'd0);
    cs_high();
    check_eq("ovr_abort",   32'(err_abort), 32'd1);
    check_eq("ovr_busy",    32'(busy), 32'd0);
    check_eq("ovr_cfg",     32'(cfg), 32'd0);
    check_eq("ovr_tvalid",  32'(bs.tvalid), 32'd0);
    check_eq("ovr_done",    32'(done_cnt - b_done), 32'd0);
    check_eq("ovr_sticky",  32'(err_overrun), 32'd1);
    rdy_mode = 1;
    tick(4);
    check_eq("ovr_no_beats", 32'(rx_d.size() - b_rx), 32'd0);

    // 8-bit frame aborted after 3 payload bits
    fill_rand(3);
    b_rx = rx_d.size();
    b_done = done_cnt;
    rdy_mode = 0;
    tick(2);
    cs_low();
    check_eq("abt_flags_cleared", 32'({err_overrun, err_abort}), 32'd0);
    send_word(16'd8);
    foreach (exp_q[i]) send_bit(exp_q[i]);
    tick(2);
    check_eq("abt_pre_tvalid", 32'(bs.tvalid), 32'd1);
    pin_cs_n = 1'b1;
    tick(3);
    check_eq("abt_tvalid", 32'(bs.tvalid), 32'd0);
    tick(4);
    check_eq("abt_abort",   32'(err_abort), 32'd1);
    check_eq("abt_busy",    32'(busy), 32'd0);
    check_eq("abt_cfg",     32'(cfg), 32'd0);
    check_eq("abt_done",    32'(done_cnt - b_done), 32'd0);
    check_eq("abt_overrun", 32'(err_overrun), 32'd0);
    rdy_mode = 1;
    tick(6);
    check_eq("abt_no_beats", 32'(rx_d.size() - b_rx), 32'd0);

    // zero-length header
    b_rx = rx_d.size();
    b_done = done_cnt;
    b_cfg = cfg_hi;
    cs_low();
    send_word(16'd0);
    tick(4);
    check_eq("zero_done",    32'(done_cnt - b_done), 32'd1);
    check_eq("zero_busy_wc", 32'(busy), 32'd1);
    cs_high();
    check_eq("zero_busy",  32'(busy), 32'd0);
    check_eq("zero_cfg",   32'(cfg_hi - b_cfg), 32'd0);
    check_eq("zero_beats", 32'(rx_d.size() - b_rx), 32'd0);
    check_eq("zero_errs",  32'({err_overrun, err_abort}), 32'd0);

    // reset in the middle of a payload
    rdy_mode = 0;
    tick(2);
    cs_low();
    send_word(16'd6);
    send_bit(1'b1);
    send_bit(1'b0);
    tick(2);
    check_eq("rstmid_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_outputs",
             32'({cfg, bs.tvalid, bs.tlast, bs.tdata[0], busy, done, err_overrun, err_abort}),
             32'd0);
    pin_cs_n = 1'b1;
    pin_sclk = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    fill_rand(6);
    run_frame("after_rst", 2);

    // randomized frames with random back-pressure
    for (int f = 0; f < 4; f++) begin
      fill_rand(int'($urandom_range(1, 20)));
      run_frame($sformatf("rand%0d", f), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: observed no end of run, required completion within bound");
    $fatal(1, "timeout");
  end

endmodule
